// File: rtl/ram_valid_tracker.sv
// Per-entry valid-bit tracker for a 2**ADDRWIDTH-deep RAM: write/invalidate/flush sweep, count, flags; RAM_VALID_FIRST_FREE_EN adds a first-free encoder.
// Latency: all state updates one edge after the command; no backpressure, commands arriving while BUSY are dropped.
module ram_valid_tracker #(
  parameter int ADDRWIDTH = 3
) (
  input  logic                        CLK,
  input  logic                        RESET,
  input  logic                        WR,
  input  logic [ADDRWIDTH-1:0]        WADDR,
  input  logic                        INV,
  input  logic [ADDRWIDTH-1:0]        IADDR,
  input  logic                        FLUSH,
  input  logic [ADDRWIDTH-1:0]        RADDR,
  output logic                        VALID,
  output logic [ADDRWIDTH:0]          COUNT,
  output logic                        FULL,
  output logic                        EMPTY,
  output logic                        BUSY,
  output logic                        FLUSH_DONE,
  output logic                        FREE_FOUND,
  output logic [ADDRWIDTH-1:0]        FREE_ADDR,
  output logic [(1<<ADDRWIDTH)-1:0]   V_LED
);

  localparam int DEPTH = 1 << ADDRWIDTH;
  localparam int CNT_W = ADDRWIDTH + 1;

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_FLUSH = 1'b1
  } state_t;

  state_t               state_q;
  state_t               state_d;
  logic [DEPTH-1:0]     valid_q;
  logic [DEPTH-1:0]     valid_d;
  logic [CNT_W-1:0]     count_q;
  logic [CNT_W-1:0]     count_d;
  logic [ADDRWIDTH-1:0] ptr_q;
  logic [ADDRWIDTH-1:0] ptr_d;
  logic                 flush_done_q;
  logic                 sweep_last;
  logic                 inc;
  logic                 dec;

  assign sweep_last = (state_q == S_FLUSH) && (&ptr_q);

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (FLUSH) state_d = S_FLUSH;
      S_FLUSH: if (sweep_last) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    BUSY = (state_q == S_FLUSH);
  end

  // Net count change is at most one step: an INV hitting the WR address is suppressed so WR wins.
  always_comb begin
    valid_d = valid_q;
    ptr_d   = ptr_q;
    inc     = 1'b0;
    dec     = 1'b0;
    if (state_q == S_IDLE) begin
      if (INV && !(WR && (WADDR == IADDR))) begin
        valid_d[IADDR] = 1'b0;
        dec            = valid_q[IADDR];
      end
      if (WR) begin
        valid_d[WADDR] = 1'b1;
        inc            = !valid_q[WADDR];
      end
      if (FLUSH) ptr_d = '0;
    end else begin
      valid_d[ptr_q] = 1'b0;
      dec            = valid_q[ptr_q];
      ptr_d          = ptr_q + ADDRWIDTH'(1);
    end
    count_d = count_q + CNT_W'(inc) - CNT_W'(dec);
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      valid_q      <= '0;
      count_q      <= '0;
      ptr_q        <= '0;
      flush_done_q <= 1'b0;
    end else begin
      valid_q      <= valid_d;
      count_q      <= count_d;
      ptr_q        <= ptr_d;
      flush_done_q <= sweep_last;
    end
  end

  assign VALID      = valid_q[RADDR];
  assign COUNT      = count_q;
  assign FULL       = (count_q == CNT_W'(DEPTH));
  assign EMPTY      = (count_q == '0);
  assign FLUSH_DONE = flush_done_q;
  assign V_LED      = valid_q;

`ifdef RAM_VALID_FIRST_FREE_EN
  logic [ADDRWIDTH-1:0] free_addr;

  // Scan from the top so the lowest invalid index is the last one written.
  always_comb begin
    free_addr = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (!valid_q[i]) free_addr = ADDRWIDTH'(i);
    end
  end

  assign FREE_FOUND = ~FULL;
  assign FREE_ADDR  = FULL ? '0 : free_addr;
`else
  assign FREE_FOUND = 1'b0;
  assign FREE_ADDR  = '0;
`endif

endmodule

// File: tb/tb_ram_valid_tracker.sv
// Directed bench for ram_valid_tracker; stimulus queues expected values per cycle, a negedge monitor compares them.
module tb_ram_valid_tracker;

  localparam int AW = 3;

  logic          CLK = 1'b0;
  logic          RESET = 1'b1;
  logic          WR = 1'b0;
  logic [AW-1:0] WADDR = '0;
  logic          INV = 1'b0;
  logic [AW-1:0] IADDR = '0;
  logic          FLUSH = 1'b0;
  logic [AW-1:0] RADDR = '0;
  logic          VALID;
  logic [AW:0]   COUNT;
  logic          FULL;
  logic          EMPTY;
  logic          BUSY;
  logic          FLUSH_DONE;
  logic          FREE_FOUND;
  logic [AW-1:0] FREE_ADDR;
  logic [7:0]    V_LED;

  ram_valid_tracker #(.ADDRWIDTH(AW)) dut (
    .CLK(CLK), .RESET(RESET), .WR(WR), .WADDR(WADDR), .INV(INV), .IADDR(IADDR),
    .FLUSH(FLUSH), .RADDR(RADDR), .VALID(VALID), .COUNT(COUNT), .FULL(FULL),
    .EMPTY(EMPTY), .BUSY(BUSY), .FLUSH_DONE(FLUSH_DONE), .FREE_FOUND(FREE_FOUND),
    .FREE_ADDR(FREE_ADDR), .V_LED(V_LED)
  );

  always #5 CLK = ~CLK;

  localparam int F_COUNT = 0, F_LED = 1, F_VALID = 2, F_FULL = 3, F_EMPTY = 4,
                 F_BUSY = 5, F_DONE = 6, F_FFOUND = 7, F_FADDR = 8;

  typedef struct {
    int          cyc;
    int          fld;
    logic [31:0] exp;
  } chk_t;

  chk_t sb_q[$];
  int   cyc_cnt = 0;
  int   n_cmp = 0;
  int   n_bad = 0;

  always @(posedge CLK) cyc_cnt = cyc_cnt + 1;

  function automatic string fname(input int f);
    case (f)
      F_COUNT:  return "count";
      F_LED:    return "v_led";
      F_VALID:  return "valid";
      F_FULL:   return "full";
      F_EMPTY:  return "empty";
      F_BUSY:   return "busy";
      F_DONE:   return "flush_done";
      F_FFOUND: return "free_found";
      default:  return "free_addr";
    endcase
  endfunction

  function automatic logic [31:0] actual(input int f);
    case (f)
      F_COUNT:  return 32'(COUNT);
      F_LED:    return 32'(V_LED);
      F_VALID:  return 32'(VALID);
      F_FULL:   return 32'(FULL);
      F_EMPTY:  return 32'(EMPTY);
      F_BUSY:   return 32'(BUSY);
      F_DONE:   return 32'(FLUSH_DONE);
      F_FFOUND: return 32'(FREE_FOUND);
      default:  return 32'(FREE_ADDR);
    endcase
  endfunction

  always @(negedge CLK) begin
    chk_t c;
    while (sb_q.size() > 0 && sb_q[0].cyc <= cyc_cnt) begin
      c = sb_q.pop_front();
      n_cmp = n_cmp + 1;
      if (actual(c.fld) !== c.exp) begin
        n_bad = n_bad + 1;
        $display("FAIL %s: got %0h, want %0h (cycle %0d)", fname(c.fld), actual(c.fld), c.exp, c.cyc);
      end
    end
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic expect_f(input int f, input logic [31:0] v);
    chk_t c;
    c.cyc = cyc_cnt;
    c.fld = f;
    c.exp = v;
    sb_q.push_back(c);
  endtask

  task automatic expect_state(input int cnt, input logic [7:0] led);
    expect_f(F_COUNT, 32'(cnt));
    expect_f(F_LED, 32'(led));
    expect_f(F_FULL, 32'(cnt == 8));
    expect_f(F_EMPTY, 32'(cnt == 0));
  endtask

  task automatic expect_free(input logic found, input logic [AW-1:0] addr);
`ifdef RAM_VALID_FIRST_FREE_EN
    expect_f(F_FFOUND, 32'(found));
    expect_f(F_FADDR, 32'(addr));
`else
    if (found || addr != '0) begin end
    expect_f(F_FFOUND, 32'd0);
    expect_f(F_FADDR, 32'd0);
`endif
  endtask

  task automatic do_wr(input logic [AW-1:0] a);
    WR = 1'b1; WADDR = a;
    tick();
    WR = 1'b0;
  endtask

  task automatic do_inv(input logic [AW-1:0] a);
    INV = 1'b1; IADDR = a;
    tick();
    INV = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish, got timeout, want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] m;

    // 1: reset, then sparse writes and lookups
    tick();
    RESET = 1'b0;
    expect_state(0, 8'h00);
    expect_f(F_BUSY, 0);
    expect_f(F_DONE, 0);
    expect_free(1'b1, 3'd0);
    do_wr(3'd0); do_wr(3'd3); do_wr(3'd7);
    RADDR = 3'd3;
    n_cmp = n_cmp + 1;
    if (COUNT !== 4'd3) begin
      n_bad = n_bad + 1;
      $display("FAIL count: got %0h, want 3 (direct)", COUNT);
    end
    n_cmp = n_cmp + 1;
    if (V_LED !== 8'h89) begin
      n_bad = n_bad + 1;
      $display("FAIL v_led: got %0h, want 89 (direct)", V_LED);
    end
    expect_state(3, 8'h89);
    expect_f(F_VALID, 1);
    expect_free(1'b1, 3'd1);
    tick();
    RADDR = 3'd4;
    expect_f(F_VALID, 0);

    // 2: fill, rewrite, invalidate twice
    for (int i = 0; i < 8; i++) do_wr(3'(i));
    n_cmp = n_cmp + 1;
    if (FULL !== 1'b1) begin
      n_bad = n_bad + 1;
      $display("FAIL full: got %0h, want 1 (direct)", FULL);
    end
    expect_state(8, 8'hFF);
    expect_free(1'b0, 3'd0);
    do_wr(3'd5);
    expect_state(8, 8'hFF);
    do_inv(3'd5);
    expect_state(7, 8'hDF);
    do_inv(3'd5);
    expect_state(7, 8'hDF);

    // 3: simultaneous WR/INV
    do_inv(3'd2);
    expect_state(6, 8'hDB);
    expect_free(1'b1, 3'd2);
    WR = 1'b1; WADDR = 3'd2; INV = 1'b1; IADDR = 3'd2;
    tick();
    WR = 1'b0; INV = 1'b0;
    expect_state(7, 8'hDF);
    do_inv(3'd4);
    expect_state(6, 8'hCF);
    WR = 1'b1; WADDR = 3'd4; INV = 1'b1; IADDR = 3'd2;
    tick();
    WR = 1'b0; INV = 1'b0;
    expect_state(6, 8'hDB);

    // 4: full flush sweep with dropped commands while busy
    do_wr(3'd2); do_wr(3'd5);
    expect_state(8, 8'hFF);
    FLUSH = 1'b1;
    tick();
    FLUSH = 1'b0;
    expect_state(8, 8'hFF);
    expect_f(F_BUSY, 1);
    expect_f(F_DONE, 0);
    for (int j = 1; j <= 8; j++) begin
      if (j == 3) begin WR = 1'b1; WADDR = 3'd0; INV = 1'b1; IADDR = 3'd7; end
      if (j == 5) FLUSH = 1'b1;
      tick();
      WR = 1'b0; INV = 1'b0; FLUSH = 1'b0;
      m = 8'hFF << j;
      expect_state(8 - j, m);
      expect_f(F_BUSY, 32'(j < 8));
      expect_f(F_DONE, 32'(j == 8));
    end
    tick();
    n_cmp = n_cmp + 1;
    if (EMPTY !== 1'b1) begin
      n_bad = n_bad + 1;
      $display("FAIL empty: got %0h, want 1 (direct)", EMPTY);
    end
    expect_state(0, 8'h00);
    expect_f(F_BUSY, 0);
    expect_f(F_DONE, 0);

    // 5: reset abandons a sweep; the next sweep starts at entry 0
    do_wr(3'd1); do_wr(3'd6);
    expect_state(2, 8'h42);
    FLUSH = 1'b1;
    tick();
    FLUSH = 1'b0;
    tick(); tick();
    expect_state(1, 8'h40);
    expect_f(F_BUSY, 1);
    RESET = 1'b1;
    tick();
    RESET = 1'b0;
    n_cmp = n_cmp + 1;
    if (BUSY !== 1'b0) begin
      n_bad = n_bad + 1;
      $display("FAIL busy: got %0h, want 0 (direct)", BUSY);
    end
    expect_state(0, 8'h00);
    expect_f(F_BUSY, 0);
    expect_f(F_DONE, 0);
    for (int j = 0; j < 10; j++) begin
      tick();
      expect_f(F_DONE, 0);
      expect_f(F_BUSY, 0);
    end
    do_wr(3'd0); do_wr(3'd3);
    FLUSH = 1'b1;
    tick();
    FLUSH = 1'b0;
    tick();
    expect_state(1, 8'h08);
    for (int j = 2; j <= 8; j++) begin
      tick();
      expect_f(F_DONE, 32'(j == 8));
    end
    expect_state(0, 8'h00);

    // FLUSH held high re-arms straight after FLUSH_DONE
    do_wr(3'd5);
    FLUSH = 1'b1;
    tick();
    expect_f(F_BUSY, 1);
    for (int j = 1; j <= 9; j++) begin
      tick();
      expect_f(F_BUSY, 32'(j != 8));
      expect_f(F_DONE, 32'(j == 8));
    end
    FLUSH = 1'b0;
    for (int j = 2; j <= 8; j++) tick();
    expect_f(F_BUSY, 1);
    tick();
    expect_f(F_BUSY, 0);
    expect_f(F_DONE, 1);
    tick();
    expect_f(F_DONE, 0);

    // 6: first-free encoder
    do_wr(3'd0); do_wr(3'd1); do_wr(3'd2); do_wr(3'd4); do_wr(3'd5); do_wr(3'd7);
    expect_state(6, 8'hB7);
    expect_free(1'b1, 3'd3);
    do_wr(3'd3);
    expect_free(1'b1, 3'd6);
    do_wr(3'd6);
    expect_state(8, 8'hFF);
    expect_free(1'b0, 3'd0);

    tick();
    @(negedge CLK);
    #1;
    while (sb_q.size() > 0) begin
      chk_t c;
      c = sb_q.pop_front();
      n_cmp = n_cmp + 1;
      n_bad = n_bad + 1;
      $display("FAIL %s: got unchecked, want %0h (cycle %0d)", fname(c.fld), c.exp, c.cyc);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
